// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: scans the channels of a captured 4-bit mask through a
// 2-to-4 decoder ({i0,i1} = channel index, en = decoder enable). Each channel
// visit lasts DWELL enabled cycles. It runs either one pass or continuously.
// Optional build macro SCAN_BLANK_EN inserts one blanking cycle (en=0,
// old channel held) on every channel advance.
module decoder_scan_ctrl #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       one_shot,
  input  logic [3:0] chan_mask,
  output logic       i0,
  output logic       i1,
  output logic       en,
  output logic       busy,
  output logic       pass_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // Counter value in the final enabled cycle of a visit.
  localparam logic [7:0] LP_LAST = 8'(DWELL - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_chan;
  logic [3:0] r_mask;
  logic       r_one_shot;
  logic       r_i0, r_i1, r_en, r_busy, r_pass_done;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [1:0] w_chan_nxt;
  logic [3:0] w_mask_nxt;
  logic       w_one_shot_nxt;
  logic       w_en_nxt, w_busy_nxt, w_pass_done_nxt;

  // Lowest set bit of the mask; 0 when the mask is empty.
  function automatic logic [1:0] f_lowest(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) r = k[1:0];
    end
    return r;
  endfunction

  // Highest set bit of the mask; 0 when the mask is empty.
  function automatic logic [1:0] f_highest(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k <= 3; k++) begin
      if (m[k]) r = k[1:0];
    end
    return r;
  endfunction

  // Next higher set bit above cur, wrapping to the lowest set bit.
  function automatic logic [1:0] f_next(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    int         c;
    c = int'(cur);
    r = f_lowest(m);
    for (int k = 3; k >= 0; k--) begin
      if (m[k] && (k > c)) r = k[1:0];
    end
    return r;
  endfunction

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_chan_nxt     = r_chan;
    w_mask_nxt     = r_mask;
    w_one_shot_nxt = r_one_shot;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop && (chan_mask != 4'b0000)) begin
          w_state_nxt    = ST_DRIVE;
          w_cnt_nxt      = 8'd0;
          w_chan_nxt     = f_lowest(chan_mask);
          w_mask_nxt     = chan_mask;
          w_one_shot_nxt = one_shot;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
          w_chan_nxt  = 2'd0;
        end
      end
      ST_DRIVE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
          w_chan_nxt  = 2'd0;
        end else if (r_cnt != LP_LAST) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end else if (r_one_shot && (r_chan == f_highest(r_mask))) begin
          // Single pass complete: straight to IDLE, never blanked.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
          w_chan_nxt  = 2'd0;
        end else begin
`ifdef SCAN_BLANK_EN
          // Hold the old channel for one blank cycle before advancing.
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = 8'd0;
`else
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = 8'd0;
          w_chan_nxt  = f_next(r_mask, r_chan);
`endif
        end
      end
      ST_BLANK: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
          w_chan_nxt  = 2'd0;
        end else begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = 8'd0;
          w_chan_nxt  = f_next(r_mask, r_chan);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
        w_chan_nxt  = 2'd0;
      end
    endcase

    w_en_nxt        = (w_state_nxt == ST_DRIVE);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_pass_done_nxt = w_en_nxt && (w_cnt_nxt == LP_LAST) &&
                      (w_chan_nxt == f_highest(w_mask_nxt));
  end

  // State, captured configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_chan      <= 2'd0;
      r_mask      <= 4'b0000;
      r_one_shot  <= 1'b0;
      r_i0        <= 1'b0;
      r_i1        <= 1'b0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_pass_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_chan      <= w_chan_nxt;
      r_mask      <= w_mask_nxt;
      r_one_shot  <= w_one_shot_nxt;
      r_i0        <= w_chan_nxt[1];
      r_i1        <= w_chan_nxt[0];
      r_en        <= w_en_nxt;
      r_busy      <= w_busy_nxt;
      r_pass_done <= w_pass_done_nxt;
    end
  end

  assign i0        = r_i0;
  assign i1        = r_i1;
  assign en        = r_en;
  assign busy      = r_busy;
  assign pass_done = r_pass_done;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Testbench for decoder_scan_ctrl (DWELL=4). Follows SCAN_BLANK_EN if defined.
module tb_decoder_scan_ctrl;

  localparam int DW = 4;
`ifdef SCAN_BLANK_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif
  localparam int P = DW + BLK;

  logic       clk;
  logic       rst, start, stop, one_shot;
  logic [3:0] chan_mask;
  logic       i0, i1, en, busy, pass_done;
  logic [4:0] dut_out;

  int n_checks = 0;
  int n_errors = 0;

  decoder_scan_ctrl #(.DWELL(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(one_shot),
    .chan_mask(chan_mask), .i0(i0), .i1(i1), .en(en), .busy(busy),
    .pass_done(pass_done)
  );

  assign dut_out = {i0, i1, en, busy, pass_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time since scan start, split into visits of P cycles.
  bit m_active = 1'b0;
  bit m_os     = 1'b0;
  int m_t      = 0;
  int m_n      = 0;
  int m_list[4];

  function automatic bit model_past_end();
    int v, off;
    v   = m_t / P;
    off = m_t % P;
    return (v >= m_n) || ((v == m_n - 1) && (off >= DW));
  endfunction

  function automatic void model_update(input logic r, s, p, os, input logic [3:0] m);
    if (r) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (p) m_active = 1'b0;
      else begin
        m_t++;
        if (m_os && model_past_end()) m_active = 1'b0;
      end
    end else if (s && !p && (m != 4'b0000)) begin
      m_active = 1'b1;
      m_t      = 0;
      m_os     = os;
      m_n      = 0;
      for (int k = 0; k < 4; k++) if (m[k]) begin m_list[m_n] = k; m_n++; end
    end
  endfunction

  function automatic logic [4:0] model_out();
    int v, off, ch;
    logic [1:0] c;
    logic en_e, pd_e;
    if (!m_active) return 5'b00000;
    v    = m_t / P;
    off  = m_t % P;
    ch   = m_list[v % m_n];
    c    = ch[1:0];
    en_e = (off < DW);
    pd_e = (off == DW - 1) && ((v % m_n) == m_n - 1);
    return {c, en_e, 1'b1, pd_e};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, s, p, os, input logic [3:0] m);
    rst = r; start = s; stop = p; one_shot = os; chan_mask = m;
    @(posedge clk);
    #1;
    model_update(r, s, p, os, m);
  endtask

  task automatic step_chk(input logic r, s, p, os, input logic [3:0] m, input string name);
    step(r, s, p, os, m);
    check(name, {27'd0, dut_out}, {27'd0, model_out()});
  endtask

  typedef struct {
    logic       rst, start, stop, os;
    logic [3:0] mask;
    logic [4:0] exp;   // {i0,i1,en,busy,pass_done}
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, s, p, os, input logic [3:0] m, input logic [4:0] e, input string n);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.os = os; v.mask = m; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  initial begin
    int en_cnt, pd_cnt, busy_cnt;
    rst = 1'b1; start = 1'b0; stop = 1'b0; one_shot = 1'b0; chan_mask = 4'b0000;

    // Macro-independent vectors (DWELL=4).
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000, "reset");
    add(1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 5'b00000, "reset_prio");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000, "idle");
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 5'b00000, "start_mask0");
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 5'b00000, "start_stop");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 5'b00000, "idle2");
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 5'b00110, "os_ch0_c1");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 5'b00110, "os_ch0_c2");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 5'b00110, "os_ch0_c3");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 5'b00111, "os_ch0_pd");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000, "os_ch0_end");
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 5'b10110, "os_ch2_c1");
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 5'b10110, "busy_start_ign");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 5'b10110, "os_ch2_c3");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 5'b10111, "os_ch2_pd");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'b00000, "os_ch2_end");
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 5'b00110, "cont_c1");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 5'b00110, "cont_c2");
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 5'b00000, "stop_drive");
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 5'b00000, "stop_idle");

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].os, tbl[i].mask);
      check(tbl[i].name, {27'd0, dut_out}, {27'd0, tbl[i].exp});
    end

    // Full one-shot pass over all four channels.
    en_cnt = 0; pd_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 4 * P + 2; c++) begin
      step_chk(1'b0, (c == 0), 1'b0, 1'b1, 4'b1111, "pass1111");
      en_cnt   += int'(en);
      pd_cnt   += int'(pass_done);
      busy_cnt += int'(busy);
    end
    check("pass1111_en_cycles", en_cnt, 16);
    check("pass1111_pd_count", pd_cnt, 1);
    check("pass1111_busy_cycles", busy_cnt, 16 + 3 * BLK);

    // Continuous scan, stop in the 2nd cycle on channel 1.
    step_chk(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, "stop_ch1_start");
    for (int c = 0; c < P + 1; c++) step_chk(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, "stop_ch1_run");
    check("stop_ch1_on_ch1", {27'd0, dut_out}, {27'd0, 5'b01110});
    step_chk(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, "stop_ch1_stop");
    check("stop_ch1_idle", {27'd0, dut_out}, 32'd0);

    // Reset mid-drive on channel 3, then restart.
    step_chk(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, "rst_mid_start");
    for (int c = 0; c < 3 * P + 1; c++) step_chk(1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, "rst_mid_run");
    check("rst_mid_on_ch3", {27'd0, dut_out}, {27'd0, 5'b11110});
    step_chk(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, "rst_mid_rst");
    check("rst_mid_zero", {27'd0, dut_out}, 32'd0);
    for (int c = 0; c < 2 * P + 2; c++)
      step_chk(1'b0, (c == 0), 1'b0, 1'b1, 4'b1010, "rst_restart");

    // Single-channel continuous scan on channel 3.
    pd_cnt = 0;
    for (int c = 0; c < 3 * P + 1; c++) begin
      step_chk(1'b0, (c == 0), 1'b0, 1'b0, 4'b1000, "single_ch3");
      pd_cnt += int'(pass_done);
    end
    check("single_ch3_pd_count", pd_cnt, 3);
    step_chk(1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, "single_ch3_stop");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step_chk(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 29) == 0),
               1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)),
               "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
